// File: rtl/seq_chk_pkg.sv
// Shared types and defaults for the incrementing-sequence checker.
package seq_chk_pkg;

    localparam logic HUNT_ENC   = 1'b0;
    localparam logic LOCKED_ENC = 1'b1;

    typedef enum logic {
        HUNT   = HUNT_ENC,
        LOCKED = LOCKED_ENC
    } state_e;

    localparam int W_DEF        = 8;
    localparam int LOCK_CNT_DEF = 3;
    localparam int MISS_MAX_DEF = 2;
    localparam int ERR_W_DEF    = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc_i and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/incr_seq_checker.sv
// Checks that valid samples form a +1 (mod 2^W) sequence: hunts for lock, then flags mismatches.
// Define SEQ_CHK_RESYNC_EN to re-align to the received value on a mismatch instead of unlocking.
module incr_seq_checker
    import seq_chk_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int MISS_MAX = MISS_MAX_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [W-1:0]     expect_q
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           have_prev_q, have_prev_d;
    logic [MW-1:0]  match_q, match_d;
    logic [W-1:0]   expect_d;
    logic           err_pulse_q, err_pulse_d;
    logic [W-1:0]   prev_inc;
    logic [W-1:0]   expect_inc;
    logic [W-1:0]   data_inc;
`ifndef SEQ_CHK_RESYNC_EN
    localparam int SW = $clog2(MISS_MAX + 1);
    logic [SW-1:0]  miss_q, miss_d;
`endif

    assign prev_inc   = prev_q + W'(1);
    assign expect_inc = expect_q + W'(1);
    assign data_inc   = in_data + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            expect_q    <= '0;
            err_pulse_q <= 1'b0;
`ifndef SEQ_CHK_RESYNC_EN
            miss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            expect_q    <= expect_d;
            err_pulse_q <= err_pulse_d;
`ifndef SEQ_CHK_RESYNC_EN
            miss_q      <= miss_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        expect_d    = expect_q;
        err_pulse_d = 1'b0;
`ifndef SEQ_CHK_RESYNC_EN
        miss_d      = miss_q;
`endif
        if (in_valid) begin
            prev_d      = in_data;
            have_prev_d = 1'b1;
            case (state_q)
                HUNT: begin
                    // The first sample after reset/unlock only seeds prev.
                    if (have_prev_q) begin
                        if (in_data == prev_inc) begin
                            if (match_q == MW'(LOCK_CNT - 1)) begin
                                state_d  = LOCKED;
                                expect_d = data_inc;
                                match_d  = '0;
`ifndef SEQ_CHK_RESYNC_EN
                                miss_d   = '0;
`endif
                            end else begin
                                match_d = match_q + MW'(1);
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (in_data == expect_q) begin
                        expect_d = expect_inc;
`ifndef SEQ_CHK_RESYNC_EN
                        miss_d   = '0;
`endif
                    end else begin
                        err_pulse_d = 1'b1;
`ifdef SEQ_CHK_RESYNC_EN
                        expect_d = data_inc;
`else
                        expect_d = expect_inc;
                        if (miss_q == SW'(MISS_MAX - 1)) begin
                            state_d = HUNT;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + SW'(1);
                        end
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_pulse_d),
        .cnt_o (err_cnt)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_incr_seq_checker.sv
// Scoreboard bench for incr_seq_checker: driver pushes model predictions, monitor pops and compares.
module tb_incr_seq_checker;

    localparam int W        = 8;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;
    localparam int ERR_W    = 4;
    localparam int MOD      = 1 << W;
    localparam int EMAX     = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [W-1:0]     expect_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit lk;
        bit pl;
        int ec;
        int ex;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (plain integers, spec rules)
    int  m_locked, m_exp, m_prev, m_have, m_run, m_miss, m_err;
    bit  m_pulse;
    int  last_sent;

    incr_seq_checker #(
        .W(W), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ERR_W(ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .expect_q  (expect_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_exp = 0; m_prev = 0; m_have = 0;
        m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input int d);
        m_pulse = 0;
        if (!v) return;
        if (!m_locked) begin
            if (m_have) m_run = (d == (m_prev + 1) % MOD) ? m_run + 1 : 0;
            m_prev = d;
            m_have = 1;
            if (m_run >= LOCK_CNT) begin
                m_locked = 1; m_exp = (d + 1) % MOD; m_run = 0; m_miss = 0;
            end
        end else if (d == m_exp) begin
            m_exp = (m_exp + 1) % MOD;
            m_miss = 0;
        end else begin
            m_pulse = 1;
            m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
`ifdef SEQ_CHK_RESYNC_EN
            m_exp = (d + 1) % MOD;
`else
            m_exp = (m_exp + 1) % MOD;
            m_miss++;
            if (m_miss >= MISS_MAX) begin
                m_locked = 0; m_have = 1; m_prev = d; m_run = 0; m_miss = 0;
            end
`endif
        end
    endtask

    task automatic step(input bit v, input int d);
        exp_t e;
        in_valid = v;
        in_data  = W'(d);
        if (v) last_sent = d;
        model_step(v, d);
        e.lk = m_locked[0]; e.pl = m_pulse; e.ec = m_err; e.ex = m_exp;
        @(posedge clk);
        #1 sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic feed_run(input int start, input int n);
        for (int i = 0; i < n; i++) step(1'b1, (start + i) % MOD);
    endtask

    // Async reset mid-cycle with in_valid held high
    task automatic do_reset();
        in_valid = 1'b1;
        in_data  = W'($urandom_range(0, MOD - 1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_errcnt", int'(err_cnt), 0);
        chk("rst_expect", int'(expect_q), 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("locked", int'(locked), int'(e.lk));
            chk("err_pulse", int'(err_pulse), int'(e.pl));
            chk("err_cnt", int'(err_cnt), e.ec);
            if (e.lk) chk("expect_q", int'(expect_q), e.ex);
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        last_sent = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_locked", int'(locked), 0);
        chk("init_errcnt", int'(err_cnt), 0);
        chk("init_expect", int'(expect_q), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lock onto 10..13
        feed_run(10, 4);
        chk("t1_locked", int'(locked), 1);
        chk("t1_expect", int'(expect_q), 14);

        // Wrap through 0xFF -> 0x00
        do_reset();
        feed_run(8'hFA, 4);
        feed_run(8'hFE, 4);
        chk("t2_expect", int'(expect_q), 2);
        chk("t2_errcnt", int'(err_cnt), 0);

        // Two mismatches at expect=20, then relock
        do_reset();
        feed_run(16, 4);
        step(1'b1, 50);
        step(1'b1, 51);
        feed_run(52, 3);
        chk("t3_expect", int'(expect_q), 55);
        chk("t3_locked", int'(locked), 1);

        // Reset while locked; first sample after release only seeds history
        do_reset();
        feed_run(1, 3);
        chk("t6_not_locked", int'(locked), 0);
        step(1'b1, 4);

        // Drive the error counter into saturation
        for (int k = 0; k < 10; k++) begin
            feed_run(k * 20, 4);
            step(1'b1, 200);
            step(1'b0, 0);
            step(1'b1, 7);
        end
        chk("sat_errcnt", int'(err_cnt), EMAX);

        // Randomized stream: mostly +1 runs, occasional glitches and idle cycles
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r, d;
            r = $urandom_range(0, 99);
            if (r < 15) begin
                step(1'b0, $urandom_range(0, MOD - 1));
            end else begin
                d = ($urandom_range(0, 99) < 90) ? (last_sent + 1) % MOD
                                                 : $urandom_range(0, MOD - 1);
                step(1'b1, d);
            end
            if (i == 300) do_reset();
        end
        step(1'b0, 0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
